// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: 2-FF sync, kclk glitch filter, 11-bit frame FSM.
// Strobes each good scan code for one cycle; parity/framing faults pulse separate flags, no backpressure.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          r_kclk_s1, r_kclk_s2, r_kdat_s1, r_kdat_s2;
  logic          r_kclk_flt, r_kclk_flt_d;
  logic [FW-1:0] r_flt_cnt;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_keycode;
  logic          r_valid, r_perr, r_ferr, r_busy;
  logic          w_fall;

  assign w_fall = r_kclk_flt_d & ~r_kclk_flt;

  // Synchronisers and glitch filter; everything idles high so no edge is seen out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_kclk_s1    <= 1'b1;
      r_kclk_s2    <= 1'b1;
      r_kdat_s1    <= 1'b1;
      r_kdat_s2    <= 1'b1;
      r_kclk_flt   <= 1'b1;
      r_kclk_flt_d <= 1'b1;
      r_flt_cnt    <= '0;
    end else begin
      r_kclk_s1    <= kclk_i;
      r_kclk_s2    <= r_kclk_s1;
      r_kdat_s1    <= kdata_i;
      r_kdat_s2    <= r_kdat_s1;
      r_kclk_flt_d <= r_kclk_flt;
      if (r_kclk_s2 != r_kclk_flt) begin
        if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
          r_kclk_flt <= r_kclk_s2;
          r_flt_cnt  <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + FW'(1);
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_keycode <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_state == IDLE) begin
        r_to_cnt <= '0;
        if (w_fall && !r_kdat_s2) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
          r_busy    <= 1'b1;
          r_state   <= DATA;
        end
      end else if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          DATA: begin
            r_shift   <= {r_kdat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= r_kdat_s2;
            r_state <= STOP;
          end
          default: begin
            // Stop bit of 0 is a framing fault and masks any parity result.
            if (!r_kdat_s2) begin
              r_ferr <= 1'b1;
            end else if (^{r_shift, r_par}) begin
              r_keycode <= r_shift;
              r_valid   <= 1'b1;
            end else begin
              r_perr <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_to_cnt <= '0;
        r_ferr   <= 1'b1;
        r_busy   <= 1'b0;
        r_state  <= IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  assign keycode_o       = r_keycode;
  assign keycode_valid_o = r_valid;
  assign parity_err_o    = r_perr;
  assign frame_err_o     = r_ferr;
  assign busy_o          = r_busy;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed and random PS/2 frames against a frame-level outcome model.
module tb_ps2_frame_rx;

  localparam int FLT = 8;
  localparam int TO  = 200;
  localparam int HB  = 20;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       kclk_i = 1'b1;
  logic       kdata_i = 1'b1;
  logic [7:0] keycode_o;
  logic       keycode_valid_o, parity_err_o, frame_err_o, busy_o;

  int total = 0;
  int bad = 0;
  int n_vld = 0, n_perr = 0, n_ferr = 0, n_multi = 0;
  logic [7:0] exp_code = 8'h00;

  ps2_frame_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .kclk_i(kclk_i), .kdata_i(kdata_i),
    .keycode_o(keycode_o), .keycode_valid_o(keycode_valid_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (keycode_valid_o) n_vld++;
    if (parity_err_o) n_perr++;
    if (frame_err_o) n_ferr++;
    if (int'(keycode_valid_o) + int'(parity_err_o) + int'(frame_err_o) > 1) n_multi++;
  end

  task automatic waitc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then clock low; optional 3-cycle glitch in the high phase.
  task automatic send_bit(input logic b, input logic glitch);
    kdata_i = b;
    if (glitch) begin
      waitc(6); kclk_i = 1'b0; waitc(3); kclk_i = 1'b1; waitc(HB - 9);
    end else begin
      waitc(HB);
    end
    kclk_i = 1'b0;
    waitc(HB);
    kclk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gbit);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == gbit);
    kdata_i = 1'b1;
    waitc(HB);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i], 1'b0);
  endtask

  // Reference outcome: 0=valid, 1=parity error, 2=framing error.
  function automatic int outcome(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = int'(p);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (!s) return 2;
    return (ones % 2 == 1) ? 0 : 1;
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] d, input logic p, input logic s,
                           input int gbit);
    int v0, pe0, fe0, o;
    v0 = n_vld; pe0 = n_perr; fe0 = n_ferr;
    o = outcome(d, p, s);
    send_frame(d, p, s, gbit);
    waitc(10);
    if (o == 0) exp_code = d;
    check({tag, ".valid"}, n_vld - v0, (o == 0) ? 1 : 0);
    check({tag, ".perr"}, n_perr - pe0, (o == 1) ? 1 : 0);
    check({tag, ".ferr"}, n_ferr - fe0, (o == 2) ? 1 : 0);
    check({tag, ".code"}, keycode_o, exp_code);
    check({tag, ".busy"}, busy_o, 0);
  endtask

  initial begin
    int v0, fe0;
    logic [7:0] d;
    logic p, s;
    waitc(5);
    check("rst.code", keycode_o, 0);
    check("rst.flags", {keycode_valid_o, parity_err_o, frame_err_o, busy_o}, 0);
    rst_i = 1'b1;
    waitc(20);

    run_frame("good1C", 8'h1C, 1'b0, 1'b1, -1);
    run_frame("b2bF0", 8'hF0, 1'b1, 1'b1, -1);
    run_frame("b2b1C", 8'h1C, 1'b0, 1'b1, -1);
    run_frame("perr1C", 8'h1C, 1'b1, 1'b1, -1);
    run_frame("stop0", 8'h1C, 1'b0, 1'b0, -1);

    // Glitch in IDLE must not start a frame.
    kclk_i = 1'b0; waitc(3); kclk_i = 1'b1; waitc(30);
    check("glitch.idle.busy", busy_o, 0);
    run_frame("glitch29", 8'h29, 1'b1, 1'b1, 4);

    v0 = n_vld; fe0 = n_ferr;
    send_partial(8'h5A, 4);
    waitc(5);
    check("to.busy_mid", busy_o, 1);
    waitc(TO + 5);
    check("to.ferr", n_ferr - fe0, 1);
    check("to.valid", n_vld - v0, 0);
    check("to.busy", busy_o, 0);
    run_frame("after_to5A", 8'h5A, 1'b0, 1'b1, -1);

    send_partial(8'h33, 3);
    waitc(2 + $urandom_range(0, 30));
    rst_i = 1'b0;
    #1;
    check("midrst.code", keycode_o, 0);
    check("midrst.flags", {keycode_valid_o, parity_err_o, frame_err_o, busy_o}, 0);
    exp_code = 8'h00;
    kclk_i = 1'b1; kdata_i = 1'b1;
    waitc(5);
    rst_i = 1'b1;
    waitc(20);
    run_frame("after_rst76", 8'h76, 1'b0, 1'b1, -1);

    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom_range(0, 255));
      p = ~^d;
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 6) != 0);
      run_frame("rand", d, p, s, -1);
    end

    check("exclusive", n_multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
